// File: rtl/calc_pkg.sv
// Shared calculator command codes, keypad map and scanner state type.
// Also holds a helper that locates the low row in an active-low row pattern.
package calc_pkg;

    typedef enum logic [3:0] {
        CMD_0    = 4'd0,
        CMD_1    = 4'd1,
        CMD_2    = 4'd2,
        CMD_3    = 4'd3,
        CMD_4    = 4'd4,
        CMD_5    = 4'd5,
        CMD_6    = 4'd6,
        CMD_7    = 4'd7,
        CMD_8    = 4'd8,
        CMD_9    = 4'd9,
        ADD      = 4'd10,
        SUB      = 4'd11,
        MUL      = 4'd12,
        EQ       = 4'd13,
        CLR      = 4'd14,
        IDLE_CMD = 4'd15
    } cmd_t;

    // Entry order is row*4 + col.
    localparam cmd_t KEYMAP [0:15] = '{
        CMD_1, CMD_2, CMD_3, ADD,
        CMD_4, CMD_5, CMD_6, SUB,
        CMD_7, CMD_8, CMD_9, MUL,
        CLR,   CMD_0, EQ,    IDLE_CMD
    };

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        WAIT_REL
    } kscan_state_t;

    function automatic logic [1:0] low_row(input logic [3:0] pat);
        logic [1:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!pat[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad-side and command-side signals of the scanner.
// master: the scanner; slave: the keypad/calc side.
interface keypad_scan_if;

    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] cmd;
    logic       cmd_valid;

    modport master (
        input  rows,
        output cols,
        output cmd,
        output cmd_valid
    );

    modport slave (
        output rows,
        input  cols,
        input  cmd,
        input  cmd_valid
    );

endinterface

// File: rtl/sync2.sv
// Generic two-flop synchroniser for asynchronous level inputs.
// Resets to RST_VAL so idle lines look idle immediately.
module sync2 #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops to resolve metastability.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column scan, press/release debounce, one command per press.
// Column stays frozen from detection until the key is fully released.
module keypad_scan
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic            clock,
    input  logic            reset,
    keypad_scan_if.master   kp
);

    localparam int MAXP = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
    localparam int CW   = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    logic [3:0]   rows_s;
    kscan_state_t state, state_n;
    logic [1:0]   col, col_n;
    logic [CW-1:0] dwell, dwell_n;
    logic [CW-1:0] deb, deb_n;
    logic [1:0]   lrow, lrow_n;
    logic [3:0]   lpat, lpat_n;
    logic [3:0]   cols_q;
    cmd_t         cmd_q, cmd_n;
    logic         valid_q, valid_n;
    logic         one_low;

    sync2 #(
        .WIDTH   (4),
        .RST_VAL (4'hF)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (kp.rows),
        .q     (rows_s)
    );

    assign one_low = ($countones(~rows_s) == 1);

    // State, counters, latched key and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= SCAN;
            col     <= 2'd0;
            dwell   <= '0;
            deb     <= '0;
            lrow    <= 2'd0;
            lpat    <= 4'hF;
            cols_q  <= 4'b1110;
            cmd_q   <= IDLE_CMD;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            col     <= col_n;
            dwell   <= dwell_n;
            deb     <= deb_n;
            lrow    <= lrow_n;
            lpat    <= lpat_n;
            cols_q  <= ~(4'b0001 << col_n);
            cmd_q   <= cmd_n;
            valid_q <= valid_n;
        end
    end

    // Next-state logic; the command is loaded on entry so it shows during EMIT.
    always_comb begin
        state_n = state;
        col_n   = col;
        dwell_n = dwell;
        deb_n   = deb;
        lrow_n  = lrow;
        lpat_n  = lpat;
        cmd_n   = IDLE_CMD;
        valid_n = 1'b0;
        unique case (state)
            SCAN: begin
                if (dwell >= DWELL_LAST) begin
                    dwell_n = '0;
                    if (one_low) begin
                        lrow_n  = low_row(rows_s);
                        lpat_n  = rows_s;
                        deb_n   = '0;
                        state_n = DEBOUNCE;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end else begin
                    dwell_n = dwell + CW'(1);
                end
            end
            DEBOUNCE: begin
                if (rows_s != lpat) begin
                    state_n = SCAN;
                    col_n   = col + 2'd1;
                    dwell_n = '0;
                    deb_n   = '0;
                end else if (deb >= DEB_LAST) begin
                    state_n = EMIT;
                    deb_n   = '0;
                    cmd_n   = KEYMAP[{lrow, col}];
                    valid_n = (KEYMAP[{lrow, col}] != IDLE_CMD);
                end else if (deb != CNT_MAX) begin
                    deb_n = deb + CW'(1);
                end
            end
            EMIT: begin
                state_n = WAIT_REL;
                deb_n   = '0;
            end
            WAIT_REL: begin
                if (rows_s != 4'hF) begin
                    deb_n = '0;
                end else if (deb >= DEB_LAST) begin
                    state_n = SCAN;
                    col_n   = col + 2'd1;
                    dwell_n = '0;
                    deb_n   = '0;
                end else if (deb != CNT_MAX) begin
                    deb_n = deb + CW'(1);
                end
            end
            default: begin
                state_n = SCAN;
            end
        endcase
    end

    assign kp.cols      = cols_q;
    assign kp.cmd       = cmd_q;
    assign kp.cmd_valid = valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed and randomized bench for keypad_scan with a behavioural keypad.
// Expected commands come from the keypad layout, computed arithmetically.
module tb_keypad_scan;

    logic        clk;
    logic        rst;
    logic [15:0] held;
    int          vectors;
    int          errs;
    int          cyc;
    int          pulses;
    int          last_cmd;
    int          last_cyc;

    keypad_scan_if kif ();

    keypad_scan #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CYC (8)
    ) dut (
        .clock (clk),
        .reset (rst),
        .kp    (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a held key pulls its row low while its column is driven.
    always_comb begin
        kif.rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (held[r*4+c] && !kif.cols[c]) kif.rows[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (kif.cmd_valid === 1'b1) begin
            pulses++;
            last_cmd = int'(kif.cmd);
            last_cyc = cyc;
        end
        if (!rst) begin
            check("cmd_idle_rule", kif.cmd == 4'hF, !kif.cmd_valid);
        end
    end

    function automatic int model_cmd(input int r, input int c);
        if (r < 3 && c < 3) return r * 3 + c + 1;
        if (r < 3) return 10 + r;
        if (c == 0) return 14;
        if (c == 1) return 0;
        if (c == 2) return 13;
        return 15;
    endfunction

    function automatic logic [15:0] key(input int r, input int c);
        logic [15:0] k;
        k = '0;
        k[r*4+c] = 1'b1;
        return k;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input string tag, input int base,
                              input int limit, output int lat);
        lat = 0;
        while (pulses == base && lat < limit) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_arrived"}, 32'(pulses != base), 1);
    endtask

    initial begin
        int base;
        int lat;
        int stable_cyc;
        int r;
        int c;
        int hold;
        vectors  = 0;
        errs     = 0;
        cyc      = 0;
        pulses   = 0;
        last_cmd = -1;
        last_cyc = 0;
        held     = '0;
        rst      = 1'b1;
        tick(3);
        check("rst_cols", kif.cols, 4'b1110);
        check("rst_cmd", kif.cmd, 4'hF);
        check("rst_valid", kif.cmd_valid, 0);

        // Reset mid-debounce.
        held = key(0, 0);
        rst  = 1'b0;
        tick(7);
        rst = 1'b1;
        tick(1);
        check("midrst_cols", kif.cols, 4'b1110);
        check("midrst_cmd", kif.cmd, 4'hF);
        check("midrst_valid", kif.cmd_valid, 0);
        check("midrst_nopulse", pulses, 0);
        held = '0;
        tick(2);
        rst = 1'b0;
        tick(3);
        check("resume_col0", kif.cols, 4'b1110);
        tick(1);
        check("resume_col1", kif.cols, 4'b1101);
        tick(10);

        // Held key, single pulse, bounded latency.
        base = pulses;
        held = key(1, 1);
        wait_pulse("k11", base, 60, lat);
        check("k11_latency", 32'(lat <= 27), 1);
        check("k11_cmd", last_cmd, model_cmd(1, 1));
        tick(100 - lat);
        check("k11_norepeat", pulses - base, 1);
        held = '0;
        tick(30);

        // Bouncing press.
        base = pulses;
        for (int i = 0; i < 7; i++) begin
            held = (i % 2 == 0) ? key(0, 3) : '0;
            tick(3);
        end
        held       = key(0, 3);
        stable_cyc = cyc;
        wait_pulse("bounce", base, 80, lat);
        check("bounce_count", pulses - base, 1);
        check("bounce_cmd", last_cmd, model_cmd(0, 3));
        check("bounce_stable", 32'(last_cyc - stable_cyc >= 8), 1);
        held = '0;
        tick(30);

        // Unmapped key then key 0.
        base = pulses;
        held = key(3, 3);
        tick(60);
        check("unmapped_none", pulses - base, 0);
        held = '0;
        tick(30);
        held = key(3, 1);
        wait_pulse("k31", base, 60, lat);
        check("k31_cmd", last_cmd, model_cmd(3, 1));
        held = '0;
        tick(30);

        // Two rows low in one column: ambiguous, never accepted.
        base = pulses;
        held = key(0, 2) | key(1, 2);
        tick(80);
        check("ghost_none", pulses - base, 0);
        held = '0;
        tick(30);

        // Second key during hold is ignored until full release.
        base = pulses;
        held = key(0, 0);
        wait_pulse("k00", base, 60, lat);
        check("k00_cmd", last_cmd, model_cmd(0, 0));
        held = held | key(2, 2);
        tick(60);
        check("k22_ignored", pulses - base, 1);
        held = '0;
        tick(30);
        base = pulses;
        held = key(2, 2);
        wait_pulse("k22", base, 60, lat);
        check("k22_cmd", last_cmd, model_cmd(2, 2));
        held = '0;
        tick(30);

        // Random single presses.
        for (int n = 0; n < 12; n++) begin
            r    = int'($urandom_range(0, 3));
            c    = int'($urandom_range(0, 3));
            hold = int'($urandom_range(40, 80));
            base = pulses;
            held = key(r, c);
            tick(hold);
            check("rand_count", pulses - base,
                  (model_cmd(r, c) == 15) ? 0 : 1);
            if (model_cmd(r, c) != 15) begin
                check("rand_cmd", last_cmd, model_cmd(r, c));
            end
            held = '0;
            tick(30);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
